// File: rtl/btn_pkg.sv
// btn_pkg: shared repeat-FSM states and parameter defaults for the button front-end
package btn_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;
    localparam int DB_CYCLES_DEF     = 500000;
    localparam int REPEAT_DELAY_DEF  = 25000000;
    localparam int REPEAT_PERIOD_DEF = 10000000;
    localparam int CNT_W_DEF         = 32;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser followed by a counting debounce filter
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic d
);
    logic [1:0]       sync_q;
    logic             d_q, d_d;
    logic [CNT_W-1:0] c_q, c_d;
    // a new level is taken once it has disagreed for DB_CYCLES cycles plus the accepting cycle
    always_comb begin
        d_d = d_q;
        c_d = '0;
        if (sync_q[1] != d_q) begin
            if (c_q == CNT_W'(DB_CYCLES)) d_d = sync_q[1];
            else c_d = c_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            d_q    <= 1'b0;
            c_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            d_q    <= d_d;
            c_q    <= c_d;
        end
    end
    assign d = d_q;
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounced, arbitrated up/down button pulses with optional auto-repeat
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    input  logic repeat_en,
    output logic btn_up,
    output logic btn_down,
    output logic up_held,
    output logic down_held
);
    logic [1:0] held, req, pulse_d, pulse_q;
    for (genvar i = 0; i < 2; i++) begin : g_btn
        rpt_state_e       state_q, state_d;
        logic [CNT_W-1:0] t_q, t_d;
        logic             req_l;
        btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (i == 0 ? raw_up : raw_down),
            .d    (held[i])
        );
        // the timer only advances while this button is the sole one held
        always_comb begin
            state_d = state_q;
            t_d     = '0;
            req_l   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (held[i]) begin
                        req_l   = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!held[i]) state_d = IDLE;
                    else if (repeat_en && !held[1-i]) begin
                        if (t_q == CNT_W'(REPEAT_DELAY - 1)) begin
                            req_l   = 1'b1;
                            state_d = REPEAT;
                        end else t_d = t_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held[i]) state_d = IDLE;
                    else if (!repeat_en) state_d = HOLD;
                    else if (!held[1-i]) begin
                        if (t_q == CNT_W'(REPEAT_PERIOD - 1)) req_l = 1'b1;
                        else t_d = t_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                t_q     <= '0;
            end else begin
                state_q <= state_d;
                t_q     <= t_d;
            end
        end
        assign req[i] = req_l;
    end
    always_comb pulse_d = req & ~{held[0], held[1]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pulse_q <= '0;
        else pulse_q <= pulse_d;
    end
    assign btn_up    = pulse_q[0];
    assign btn_down  = pulse_q[1];
    assign up_held   = held[0];
    assign down_held = held[1];
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed scenarios checked against a behavioural window/run-length model
module tb_btn_pulse_gen;
    localparam int DB = 4, RD = 20, RP = 8, HL = DB + 3;
    logic clk = 1'b0, reset = 1'b1, raw_up = 1'b0, raw_down = 1'b0, repeat_en = 1'b0;
    logic btn_up, btn_down, up_held, down_held;
    int n_vec = 0, n_bad = 0;
    int ek, uh_first, dh_first;
    int up_at[$], dn_at[$];
    int md[2], mdp[2], run_c[2], need[2], ep[2], el[2];
    int rq, flip;
    bit rh[2][HL];

    btn_pulse_gen #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .raw_up(raw_up), .raw_down(raw_down), .repeat_en(repeat_en),
        .btn_up(btn_up), .btn_down(btn_down), .up_held(up_held), .down_held(down_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: a level is accepted once the last DB+1 synchronised samples all disagree with it;
    // pulses come from a press, or from a run of "sole holder with repeat enabled" cycles.
    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                md[b] = 0; mdp[b] = 0; run_c[b] = 0; need[b] = RD; ep[b] = 0;
                for (int k = 0; k < HL; k++) rh[b][k] = 1'b0;
            end
        end else begin
            for (int b = 0; b < 2; b++) el[b] = int'(md[b] != 0 && repeat_en && md[1-b] == 0);
            for (int b = 0; b < 2; b++) begin
                rq = 0;
                if (md[b] != 0 && mdp[b] == 0) begin
                    rq = 1; run_c[b] = 0; need[b] = RD;
                end else if (el[b] != 0) begin
                    if (run_c[b] == need[b] - 1) begin
                        rq = 1; run_c[b] = 0; need[b] = RP;
                    end else run_c[b]++;
                end else begin
                    run_c[b] = 0;
                    if (md[b] == 0 || !repeat_en) need[b] = RD;
                end
                ep[b] = int'(rq != 0 && md[1-b] == 0);
            end
            for (int b = 0; b < 2; b++) begin
                mdp[b] = md[b];
                for (int k = HL - 1; k > 0; k--) rh[b][k] = rh[b][k-1];
                rh[b][0] = (b == 0) ? raw_up : raw_down;
                flip = 1;
                for (int k = 2; k < HL; k++) if (int'(rh[b][k]) == md[b]) flip = 0;
                if (flip != 0) md[b] = 1 - md[b];
            end
        end
        #1;
        chk("btn_up", int'(btn_up), ep[0]);
        chk("btn_down", int'(btn_down), ep[1]);
        chk("up_held", int'(up_held), md[0]);
        chk("down_held", int'(down_held), md[1]);
    end

    task automatic mark();
        ek = 0; uh_first = -1; dh_first = -1;
        up_at.delete(); dn_at.delete();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #2;
            if (btn_up) up_at.push_back(ek);
            if (btn_down) dn_at.push_back(ek);
            if (up_held && uh_first < 0) uh_first = ek;
            if (down_held && dh_first < 0) dh_first = ek;
            ek++;
        end
        @(negedge clk);
    endtask

    task automatic chk_list(input string nm, input int dn, input int n,
                            input int a0 = -1, input int a1 = -1, input int a2 = -1,
                            input int a3 = -1, input int a4 = -1, input int a5 = -1);
        int ex[6];
        int q[$];
        ex = '{a0, a1, a2, a3, a4, a5};
        q = (dn != 0) ? dn_at : up_at;
        chk({nm, " count"}, q.size(), n);
        for (int i = 0; i < n; i++) chk({nm, " edge"}, (i < q.size()) ? q[i] : -1, ex[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run(5);
        // clean press, no repeat
        mark(); raw_up = 1'b1; run(50);
        chk("clean up_held rise", uh_first, 6);
        chk_list("clean up", 0, 1, 7);
        chk_list("clean down", 1, 0);
        mark(); raw_up = 1'b0; run(20);
        chk_list("clean release up", 0, 0);
        // bounce rejection
        mark();
        for (int i = 0; i < 4; i++) begin
            raw_down = (i % 2 == 0);
            run(3);
        end
        chk_list("bounce down", 1, 0);
        chk("bounce held", dh_first, -1);
        mark(); raw_down = 1'b1; run(30);
        chk_list("bounce final down", 1, 1, 7);
        chk_list("bounce up", 0, 0);
        raw_down = 1'b0; run(15);
        // auto-repeat
        repeat_en = 1'b1;
        mark(); raw_up = 1'b1; run(60);
        chk_list("repeat up", 0, 6, 7, 27, 35, 43, 51, 59);
        mark(); raw_up = 1'b0; run(20);
        chk_list("repeat stop", 0, 0);
        // simultaneous hold
        mark(); raw_up = 1'b1; run(10);
        raw_down = 1'b1; run(15);
        raw_down = 1'b0; run(40);
        chk("simul down_held rise", dh_first, 16);
        chk_list("simul up", 0, 3, 7, 51, 59);
        chk_list("simul down", 1, 0);
        raw_up = 1'b0; run(15);
        // reset while in REPEAT
        mark(); raw_up = 1'b1; run(30);
        chk_list("pre-reset up", 0, 2, 7, 27);
        reset = 1'b1; #1;
        chk("reset btn_up", int'(btn_up), 0);
        chk("reset btn_down", int'(btn_down), 0);
        chk("reset up_held", int'(up_held), 0);
        chk("reset down_held", int'(down_held), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mark(); run(20);
        chk("post-reset up_held rise", uh_first, 6);
        chk_list("post-reset up", 0, 1, 7);
        // repeat_en toggled while held
        mark(); repeat_en = 1'b0; run(30);
        chk_list("en off up", 0, 0);
        mark(); repeat_en = 1'b1; run(30);
        chk_list("en on up", 0, 2, 19, 27);
        raw_up = 1'b0; run(15);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
